// File: rtl/instr_realign_buffer.sv
// Fetch-side realignment buffer: turns word-aligned 32-bit fetch words into whole
// RISC-V instructions (16- or 32-bit) with their PC, handling straddles and redirects.
module instr_realign_buffer #(
  parameter int          ADDR_W   = 64,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              fetch_valid_i,
  output logic              fetch_ready_o,
  input  logic [31:0]       fetch_word_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_is_c_o
);

  localparam logic [ADDR_W-1:0] RESET_HEAD = RESET_PC[ADDR_W-1:0] & ~ADDR_W'(1);

  logic [15:0]       r_hw [4];
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_headPc;
  logic              r_dropLo;

  logic              w_isC;
  logic [2:0]        w_need;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_popN;
  logic [2:0]        w_pushN;
  logic [2:0]        w_remain;
  logic [2:0]        w_cntNext;
  logic [15:0]       w_shifted [4];
  logic [15:0]       w_hwNext [4];

  assign w_isC         = (r_hw[0][1:0] != 2'b11);
  assign w_need        = w_isC ? 3'd1 : 3'd2;
  assign instr_valid_o = (r_cnt >= w_need);
  assign instr_o       = w_isC ? {16'h0, r_hw[0]} : {r_hw[1], r_hw[0]};
  assign instr_pc_o    = r_headPc;
  assign instr_is_c_o  = w_isC;
  assign fetch_ready_o = (r_cnt <= 3'd2);

  assign w_push    = fetch_valid_i && fetch_ready_o;
  assign w_pop     = instr_valid_o && instr_ready_i;
  assign w_popN    = w_pop ? (w_isC ? 2'd1 : 2'd2) : 2'd0;
  assign w_pushN   = !w_push ? 3'd0 : (r_dropLo ? 3'd1 : 3'd2);
  assign w_remain  = r_cnt - {1'b0, w_popN};
  assign w_cntNext = w_remain + w_pushN;

  // Pop shifts the queue down first; the pushed halfwords land right after what remains.
  always_comb begin
    case (w_popN)
      2'd1:    w_shifted = '{r_hw[1], r_hw[2], r_hw[3], r_hw[3]};
      2'd2:    w_shifted = '{r_hw[2], r_hw[3], r_hw[3], r_hw[3]};
      default: w_shifted = r_hw;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_hwNext[i] = w_shifted[i];
      if (w_push) begin
        if (r_dropLo) begin
          if (3'(i) == w_remain) w_hwNext[i] = fetch_word_i[31:16];
        end else begin
          if (3'(i) == w_remain)        w_hwNext[i] = fetch_word_i[15:0];
          if (3'(i) == w_remain + 3'd1) w_hwNext[i] = fetch_word_i[31:16];
        end
      end
    end
  end

  // Halfword storage carries no reset: empty slots are don't-care.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= 3'd0;
      r_headPc <= RESET_HEAD;
      r_dropLo <= RESET_PC[1];
    end else if (flush_i) begin
      r_cnt    <= 3'd0;
      r_headPc <= flush_pc_i & ~ADDR_W'(1);
      r_dropLo <= flush_pc_i[1];
    end else begin
      r_cnt    <= w_cntNext;
      r_hw     <= w_hwNext;
      r_headPc <= r_headPc + (ADDR_W'(w_popN) << 1);
      if (w_push) r_dropLo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_realign_buffer.sv
// Directed bench for instr_realign_buffer: a 64-bit-PC instance plus a 16-bit-PC
// instance sharing the same inputs, the latter used for PC wrap-around.
module tb_instr_realign_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [63:0] flushPc;
  logic        fetchValid;
  logic [31:0] fetchWord;
  logic        instrReady;

  logic        fetchReady, instrValid, instrIsC;
  logic [31:0] instrData;
  logic [63:0] instrPc;

  logic        fetchReady16, instrValid16, instrIsC16;
  logic [31:0] instrData16;
  logic [15:0] instrPc16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_realign_buffer u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flushPc),
    .fetch_valid_i(fetchValid), .fetch_ready_o(fetchReady), .fetch_word_i(fetchWord),
    .instr_valid_o(instrValid), .instr_ready_i(instrReady), .instr_o(instrData),
    .instr_pc_o(instrPc), .instr_is_c_o(instrIsC)
  );

  instr_realign_buffer #(.ADDR_W(16), .RESET_PC(64'h0)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_pc_i(flushPc[15:0]),
    .fetch_valid_i(fetchValid), .fetch_ready_o(fetchReady16), .fetch_word_i(fetchWord),
    .instr_valid_o(instrValid16), .instr_ready_i(instrReady), .instr_o(instrData16),
    .instr_pc_o(instrPc16), .instr_is_c_o(instrIsC16)
  );

  // Drive one cycle of inputs from the falling edge, then return at the next falling edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic ready,
                               input logic fl, input logic [63:0] fpc);
    fetchValid = valid;
    fetchWord  = word;
    instrReady = ready;
    flush      = fl;
    flushPc    = fpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; flushPc = '0;
    fetchValid = 1'b0; fetchWord = '0; instrReady = 1'b0;
    @(negedge clk);
    applyStimulus(0, 32'h0, 0, 0, 64'h0);
    applyStimulus(0, 32'h0, 0, 0, 64'h0);
    rst = 1'b0;
    checkOutput("reset_valid", 64'(instrValid), 64'h0);
    checkOutput("reset_fetch_ready", 64'(fetchReady), 64'h1);
    checkOutput("reset_pc", instrPc, 64'h8000_0000);
    checkOutput("reset_pc16", 64'(instrPc16), 64'h0);

    // Two compressed instructions in one word
    applyStimulus(1, 32'h4501_4505, 1, 0, 64'h0);
    checkOutput("c2_valid0", 64'(instrValid), 64'h1);
    checkOutput("c2_instr0", 64'(instrData), 64'h4505);
    checkOutput("c2_isc0", 64'(instrIsC), 64'h1);
    checkOutput("c2_pc0", instrPc, 64'h8000_0000);
    applyStimulus(0, 32'h0, 1, 0, 64'h0);
    checkOutput("c2_instr1", 64'(instrData), 64'h4501);
    checkOutput("c2_pc1", instrPc, 64'h8000_0002);
    applyStimulus(0, 32'h0, 1, 0, 64'h0);
    checkOutput("c2_empty", 64'(instrValid), 64'h0);

    // Straddling 32-bit instruction
    applyStimulus(0, 32'h0, 0, 1, 64'h8000_0000);
    applyStimulus(1, 32'h0513_4505, 1, 0, 64'h0);
    checkOutput("str_instr0", 64'(instrData), 64'h4505);
    checkOutput("str_pc0", instrPc, 64'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 1, 0, 64'h0);
      checkOutput("str_wait_valid", 64'(instrValid), 64'h0);
    end
    applyStimulus(1, 32'h0000_0010, 1, 0, 64'h0);
    checkOutput("str_valid1", 64'(instrValid), 64'h1);
    checkOutput("str_instr1", 64'(instrData), 64'h0010_0513);
    checkOutput("str_isc1", 64'(instrIsC), 64'h0);
    checkOutput("str_pc1", instrPc, 64'h8000_0002);

    // Backpressure: third word must be held, not lost
    applyStimulus(0, 32'h0, 0, 1, 64'h8000_0000);
    applyStimulus(1, 32'h0010_0513, 0, 0, 64'h0);
    checkOutput("bp_ready1", 64'(fetchReady), 64'h1);
    applyStimulus(1, 32'h0010_0513, 0, 0, 64'h0);
    checkOutput("bp_ready2", 64'(fetchReady), 64'h0);
    checkOutput("bp_instr0", 64'(instrData), 64'h0010_0513);
    applyStimulus(1, 32'h0010_0513, 0, 0, 64'h0);
    checkOutput("bp_hold_ready", 64'(fetchReady), 64'h0);
    checkOutput("bp_hold_pc", instrPc, 64'h8000_0000);
    applyStimulus(1, 32'h0010_0513, 1, 0, 64'h0);
    checkOutput("bp_pc1", instrPc, 64'h8000_0004);
    checkOutput("bp_ready3", 64'(fetchReady), 64'h1);
    applyStimulus(1, 32'h0010_0513, 1, 0, 64'h0);
    checkOutput("bp_instr2", 64'(instrData), 64'h0010_0513);
    checkOutput("bp_pc2", instrPc, 64'h8000_0008);
    applyStimulus(0, 32'h0, 1, 0, 64'h0);
    checkOutput("bp_drained", 64'(instrValid), 64'h0);
    checkOutput("bp_pc3", instrPc, 64'h8000_000C);

    // Halfword redirect with a push in the flush cycle
    applyStimulus(1, 32'h0010_0513, 0, 0, 64'h0);
    checkOutput("rd_pre_valid", 64'(instrValid), 64'h1);
    applyStimulus(1, 32'hDEAD_BEEF, 1, 1, 64'h8000_0102);
    checkOutput("rd_valid", 64'(instrValid), 64'h0);
    checkOutput("rd_ready", 64'(fetchReady), 64'h1);
    checkOutput("rd_pc", instrPc, 64'h8000_0102);
    applyStimulus(1, 32'h1234_4505, 1, 0, 64'h0);
    checkOutput("rd_instr", 64'(instrData), 64'h1234);
    checkOutput("rd_isc", 64'(instrIsC), 64'h1);
    checkOutput("rd_pc2", instrPc, 64'h8000_0102);
    applyStimulus(0, 32'h0, 1, 0, 64'h0);
    checkOutput("rd_single", 64'(instrValid), 64'h0);
    checkOutput("rd_pc3", instrPc, 64'h8000_0104);

    // 16-bit PC wrap with simultaneous push and pop
    applyStimulus(0, 32'h0, 0, 1, 64'hFFFE);
    checkOutput("wr_pc_flush", 64'(instrPc16), 64'hFFFE);
    applyStimulus(1, 32'h4505_0000, 1, 0, 64'h0);
    checkOutput("wr_instr0", 64'(instrData16), 64'h4505);
    checkOutput("wr_pc0", 64'(instrPc16), 64'hFFFE);
    applyStimulus(1, 32'h0001_0001, 1, 0, 64'h0);
    checkOutput("wr_instr1", 64'(instrData16), 64'h0001);
    checkOutput("wr_pc1", 64'(instrPc16), 64'h0000);
    applyStimulus(1, 32'h0001_0001, 1, 0, 64'h0);
    checkOutput("wr_pc2", 64'(instrPc16), 64'h0002);
    checkOutput("wr_cnt3_ready", 64'(fetchReady16), 64'h0);
    applyStimulus(0, 32'h0, 0, 1, 64'h0);
    applyStimulus(1, 32'h0010_0513, 1, 0, 64'h0);
    checkOutput("wr32_instr", 64'(instrData16), 64'h0010_0513);
    applyStimulus(1, 32'h0010_0513, 1, 0, 64'h0);
    checkOutput("wr32_pc", 64'(instrPc16), 64'h0004);
    checkOutput("wr32_cnt2_ready", 64'(fetchReady16), 64'h1);
    checkOutput("wr32_valid", 64'(instrValid16), 64'h1);
    checkOutput("wr32_isc", 64'(instrIsC16), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
